// File: rtl/gsm_tx_arbiter.sv
// Round-robin owner of a single UART byte transmitter: grants one requester per message,
// forwards its bytes through the tx_enable/tx_done handshake, inserts a quiet gap and watches for stalls.
module gsm_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int GAP_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] byte_data,
  input  logic [NUM_REQ-1:0]   byte_last,
  output logic [NUM_REQ-1:0]   byte_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   msg_done,
  output logic                 tx_enable,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_ACK, S_GAP} state_t;
  localparam state_t AFTER_MSG = HAS_GAP ? S_GAP : S_IDLE;

  state_t              state_q;
  logic [IW-1:0]       g_q;
  logic [IW-1:0]       rr_q;
  logic                last_q;
  logic [GW-1:0]       gap_q;
  logic [TW-1:0]       tmo_q;
  logic [NUM_REQ-1:0]  byte_ack_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  msg_done_q;
  logic                tx_enable_q;
  logic [7:0]          tx_data_q;
  logic                busy_q;
  logic                timeout_err_q;

  logic                found_d;
  logic [IW-1:0]       cand_d;
  logic [IW-1:0]       pick_d;
  logic [IW-1:0]       next_ptr_d;
  logic [NUM_REQ-1:0]  pick_oh_d;
  logic [NUM_REQ-1:0]  g_oh_d;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return sum[IW-1:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin scan: walk downwards from the farthest candidate so the one nearest rr_q wins.
  always_comb begin
    found_d = 1'b0;
    cand_d  = rr_q;
    pick_d  = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_d  = wrap_add(rr_q, k);
      found_d = found_d | req[cand_d];
      pick_d  = req[cand_d] ? cand_d : pick_d;
    end
    next_ptr_d = wrap_add(g_q, 1);
    pick_oh_d  = onehot(pick_d);
    g_oh_d     = onehot(g_q);
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      g_q           <= '0;
      rr_q          <= '0;
      last_q        <= 1'b0;
      gap_q         <= '0;
      tmo_q         <= '0;
      byte_ack_q    <= '0;
      grant_q       <= '0;
      msg_done_q    <= '0;
      tx_enable_q   <= 1'b0;
      tx_data_q     <= 8'h00;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      byte_ack_q    <= '0;
      msg_done_q    <= '0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            g_q     <= pick_d;
            grant_q <= pick_oh_d;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!req[g_q]) begin
            grant_q <= '0;
            rr_q    <= next_ptr_d;
            gap_q   <= '0;
            busy_q  <= HAS_GAP;
            state_q <= AFTER_MSG;
          end else begin
            tx_data_q   <= byte_data[8*g_q +: 8];
            last_q      <= byte_last[g_q];
            tmo_q       <= '0;
            tx_enable_q <= 1'b1;
            state_q     <= S_SEND;
          end
        end
        S_SEND: begin
          // tx_done wins over a simultaneous terminal count.
          if (tx_done) begin
            tx_enable_q <= 1'b0;
            tx_data_q   <= 8'h00;
            byte_ack_q  <= g_oh_d;
            msg_done_q  <= last_q ? g_oh_d : '0;
            state_q     <= S_ACK;
          end else if (tmo_q == TMO_LAST) begin
            tx_enable_q   <= 1'b0;
            tx_data_q     <= 8'h00;
            timeout_err_q <= 1'b1;
            grant_q       <= '0;
            rr_q          <= next_ptr_d;
            gap_q         <= '0;
            busy_q        <= HAS_GAP;
            state_q       <= AFTER_MSG;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_ACK: begin
          if (last_q) begin
            grant_q <= '0;
            rr_q    <= next_ptr_d;
            gap_q   <= '0;
            busy_q  <= HAS_GAP;
            state_q <= AFTER_MSG;
          end else begin
            state_q <= S_LOAD;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: begin
          state_q     <= S_IDLE;
          grant_q     <= '0;
          tx_enable_q <= 1'b0;
          tx_data_q   <= 8'h00;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ack    = byte_ack_q;
  assign grant       = grant_q;
  assign msg_done    = msg_done_q;
  assign tx_enable   = tx_enable_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_gsm_tx_arbiter.sv
// Directed bench for gsm_tx_arbiter: behavioural requesters and UART stand-in, logged events
// compared against hand-computed sequences.
module tb_gsm_tx_arbiter;

  localparam int NR     = 3;
  localparam int GAP    = 4;
  localparam int TMO    = 20;
  localparam int TX_LAT = 10;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] byte_data;
  logic [2:0]  byte_last;
  logic [2:0]  byte_ack;
  logic [2:0]  grant;
  logic [2:0]  msg_done;
  logic        tx_enable;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic        timeout_err;

  gsm_tx_arbiter #(
    .NUM_REQ(NR),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .byte_data(byte_data),
    .byte_last(byte_last),
    .byte_ack(byte_ack),
    .grant(grant),
    .msg_done(msg_done),
    .tx_enable(tx_enable),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] msg [3][4];
  int len   [3];
  int idx   [3];
  int rearm [3];

  bit tx_auto;
  bit tx_force;
  int tx_cnt;

  logic [7:0] q_data  [$];
  logic [2:0] q_ack   [$];
  logic [2:0] q_done  [$];
  logic [2:0] q_grant [$];
  int         q_low   [$];
  int         q_hi    [$];
  int  low_run, hi_run, gapc, te_cnt, done_cnt;
  logic       prev_en;
  logic [2:0] prev_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] data_at(input int k);
    return (k < q_data.size()) ? 32'(q_data[k]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] ack_at(input int k);
    return (k < q_ack.size()) ? 32'(q_ack[k]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] done_at(input int k);
    return (k < q_done.size()) ? 32'(q_done[k]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] grant_at(input int k);
    return (k < q_grant.size()) ? 32'(q_grant[k]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] low_at(input int k);
    return (k < q_low.size()) ? 32'(q_low[k]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] hi_at(input int k);
    return (k < q_hi.size()) ? 32'(q_hi[k]) : 32'hFFFF_FFFF;
  endfunction

  task automatic drive_bytes();
    for (int i = 0; i < 3; i++) begin
      byte_data[8*i +: 8] = (idx[i] < 4) ? msg[i][idx[i]] : 8'h00;
      byte_last[i]        = (idx[i] == len[i] - 1);
    end
  endtask

  task automatic set_msg(input int r, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int n);
    msg[r][0] = b0;
    msg[r][1] = b1;
    msg[r][2] = b2;
    msg[r][3] = 8'h00;
    len[r]    = n;
    idx[r]    = 0;
    drive_bytes();
  endtask

  task automatic clear_logs();
    q_data.delete();
    q_ack.delete();
    q_done.delete();
    q_grant.delete();
    q_low.delete();
    q_hi.delete();
    low_run    = 0;
    hi_run     = 0;
    gapc       = 0;
    te_cnt     = 0;
    done_cnt   = 0;
    prev_en    = tx_enable;
    prev_grant = grant;
  endtask

  // One clock: requesters react to the ack/done of the ending cycle, UART model runs, events are logged.
  task automatic step();
    logic [2:0] ack_pre;
    logic [2:0] done_pre;
    ack_pre  = byte_ack;
    done_pre = msg_done;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (ack_pre[i]) begin
        if (done_pre[i]) begin
          idx[i] = 0;
          if (rearm[i] > 0) rearm[i]--;
          else req[i] = 1'b0;
        end else begin
          idx[i]++;
        end
      end
    end
    drive_bytes();
    if (tx_enable) tx_cnt++;
    else tx_cnt = 0;
    tx_done = tx_force || (tx_auto && tx_enable && (tx_cnt == TX_LAT));
    if (tx_enable) begin
      if (!prev_en) begin
        q_data.push_back(tx_data);
        q_low.push_back(low_run);
        hi_run = 0;
      end
      hi_run++;
    end else begin
      if (prev_en) begin
        q_hi.push_back(hi_run);
        low_run = 0;
      end
      low_run++;
    end
    prev_en = tx_enable;
    if (byte_ack != 3'b000) begin
      q_ack.push_back(byte_ack);
      q_done.push_back(msg_done);
    end
    if (msg_done != 3'b000) done_cnt++;
    if (timeout_err) te_cnt++;
    if (grant != 3'b000 && grant != prev_grant) q_grant.push_back(grant);
    prev_grant = grant;
    if (busy && grant == 3'b000) gapc++;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    n = 0;
    step();
    while ((busy || req != 3'b000) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_quiet"}, 32'(busy | (|req)), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = 3'b000;
    tx_done   = 1'b0;
    tx_auto   = 1'b1;
    tx_force  = 1'b0;
    tx_cnt    = 0;
    byte_data = 24'h0;
    byte_last = 3'b000;
    for (int i = 0; i < 3; i++) begin
      rearm[i] = 0;
      set_msg(i, 8'h00, 8'h00, 8'h00, 1);
    end
    step();

    // Reset state and a 3-byte message from requester 0.
    do_reset();
    check("rst_tx_enable", 32'(tx_enable), 32'd0);
    check("rst_grant",     32'(grant),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_outs",      32'({byte_ack, msg_done, timeout_err, tx_data}), 32'd0);
    set_msg(0, 8'h41, 8'h54, 8'h0D, 3);
    clear_logs();
    req = 3'b001;
    step();
    check("t1_grant_next", 32'(grant), 32'd1);
    check("t1_busy",       32'(busy),  32'd1);
    wait_quiet("t1", 300);
    check("t1_nbytes", 32'(q_data.size()), 32'd3);
    check("t1_b0", data_at(0), 32'h41);
    check("t1_b1", data_at(1), 32'h54);
    check("t1_b2", data_at(2), 32'h0D);
    check("t1_nack", 32'(q_ack.size()), 32'd3);
    check("t1_ack0", ack_at(0), 32'd1);
    check("t1_ack2", ack_at(2), 32'd1);
    check("t1_done0", done_at(0), 32'd0);
    check("t1_done1", done_at(1), 32'd0);
    check("t1_done2", done_at(2), 32'd1);
    check("t1_ndone", 32'(done_cnt), 32'd1);
    check("t1_low1", low_at(1), 32'd2);
    check("t1_low2", low_at(2), 32'd2);
    check("t1_hi0", hi_at(0), 32'(TX_LAT));
    check("t1_gap", 32'(gapc), 32'(GAP));
    check("t1_no_te", 32'(te_cnt), 32'd0);

    // All three requesting single-byte messages; requester 0 re-requests once.
    do_reset();
    set_msg(0, 8'hA0, 8'h00, 8'h00, 1);
    set_msg(1, 8'hA1, 8'h00, 8'h00, 1);
    set_msg(2, 8'hA2, 8'h00, 8'h00, 1);
    rearm[0] = 1;
    clear_logs();
    req = 3'b111;
    step();
    check("t2_first_grant", 32'(grant), 32'd1);
    wait_quiet("t2", 600);
    check("t2_ngrant", 32'(q_grant.size()), 32'd4);
    check("t2_g0", grant_at(0), 32'd1);
    check("t2_g1", grant_at(1), 32'd2);
    check("t2_g2", grant_at(2), 32'd4);
    check("t2_g3", grant_at(3), 32'd1);
    check("t2_d0", data_at(0), 32'hA0);
    check("t2_d1", data_at(1), 32'hA1);
    check("t2_d2", data_at(2), 32'hA2);
    check("t2_d3", data_at(3), 32'hA0);
    check("t2_nsend", 32'(q_data.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_ack%0d", k), ack_at(k), grant_at(k));
      check($sformatf("t2_done_with_ack%0d", k), done_at(k), grant_at(k));
    end
    check("t2_gap", 32'(gapc), 32'(4 * GAP));

    // Stalled transmitter while requester 1 owns it; requester 2 waits.
    do_reset();
    set_msg(1, 8'h31, 8'h00, 8'h00, 1);
    set_msg(2, 8'h32, 8'h00, 8'h00, 1);
    clear_logs();
    tx_auto = 1'b0;
    req = 3'b110;
    step();
    check("t4_grant", 32'(grant), 32'd2);
    for (int n = 0; n < 60 && !timeout_err; n++) step();
    check("t4_te_seen", 32'(timeout_err), 32'd1);
    check("t4_te_txen", 32'(tx_enable), 32'd0);
    check("t4_te_grant", 32'(grant), 32'd0);
    check("t4_te_busy", 32'(busy), 32'd1);
    req[1]  = 1'b0;
    tx_auto = 1'b1;
    wait_quiet("t4", 300);
    check("t4_hi0", hi_at(0), 32'(TMO));
    check("t4_te_cnt", 32'(te_cnt), 32'd1);
    check("t4_g0", grant_at(0), 32'd2);
    check("t4_g1", grant_at(1), 32'd4);
    check("t4_d1", data_at(1), 32'h32);
    check("t4_nack", 32'(q_ack.size()), 32'd1);
    check("t4_ack0", ack_at(0), 32'd4);
    check("t4_done0", done_at(0), 32'd4);

    // Requester 0 withdraws during the ACK of its first byte.
    do_reset();
    set_msg(0, 8'h11, 8'h22, 8'h33, 3);
    set_msg(1, 8'h5A, 8'h00, 8'h00, 1);
    clear_logs();
    req = 3'b001;
    step();
    for (int n = 0; n < 60 && byte_ack == 3'b000; n++) step();
    check("t5_ack", 32'(byte_ack), 32'd1);
    check("t5_ack_nodone", 32'(msg_done), 32'd0);
    req[0] = 1'b0;
    wait_quiet("t5", 200);
    check("t5_nbytes", 32'(q_data.size()), 32'd1);
    check("t5_d0", data_at(0), 32'h11);
    check("t5_nack", 32'(q_ack.size()), 32'd1);
    check("t5_ndone", 32'(done_cnt), 32'd0);
    check("t5_gap", 32'(gapc), 32'(GAP));
    clear_logs();
    req = 3'b011;
    step();
    check("t5_rr_after_abort", 32'(grant), 32'd2);
    wait_quiet("t5b", 200);
    check("t5b_d0", data_at(0), 32'h5A);

    // Reset while a byte from requester 2 is in flight.
    set_msg(2, 8'h77, 8'h00, 8'h00, 1);
    clear_logs();
    tx_auto = 1'b0;
    req = 3'b100;
    step();
    check("t6_grant", 32'(grant), 32'd4);
    for (int n = 0; n < 10 && !tx_enable; n++) step();
    check("t6_txen", 32'(tx_enable), 32'd1);
    check("t6_txdata", 32'(tx_data), 32'h77);
    step();
    step();
    rst = 1'b1;
    req = 3'b000;
    step();
    rst = 1'b0;
    check("t6_rst_txen", 32'(tx_enable), 32'd0);
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_outs", 32'({byte_ack, msg_done, timeout_err, tx_data}), 32'd0);
    tx_force = 1'b1;
    step();
    tx_force = 1'b0;
    step();
    check("t6_late_ack", 32'(byte_ack), 32'd0);
    step();
    check("t6_late_busy", 32'(busy), 32'd0);
    check("t6_late_nack", 32'(q_ack.size()), 32'd0);
    tx_auto = 1'b1;
    clear_logs();
    req = 3'b110;
    step();
    check("t6_rr_reset", 32'(grant), 32'd2);
    wait_quiet("t6", 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gsm_tx_arbiter.md
Name: gsm_tx_arbiter

Overview:
- Shares the single UART byte transmitter (tx_enable/tx_data/tx_done handshake, driven through the bps generator) between NUM_REQ message requesters, e.g. the per-command GSM AT-string generators.
- Grants one requester for a whole message, round-robin, and forwards its bytes one at a time.
- Enforces a quiet gap between messages so the GSM modem can process each command.
- Detects a stalled transmitter with a per-byte timeout.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
GAP_CYCLES, 50000, idle clk cycles between end of one message and next grant (0 = no gap)
TIMEOUT_CYCLES, 100000, max clk cycles waiting for tx_done per byte

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, reset is synchronous and active-high
req  in  NUM_REQ  per-requester level request; held high until msg_done or abort
byte_data  in  8*NUM_REQ  current byte of requester i at [8i+7:8i]
byte_last  in  NUM_REQ  current byte of requester i is final byte of its message
byte_ack  out  NUM_REQ  1-cycle pulse: current byte of granted requester consumed; requester advances to next byte
grant  out  NUM_REQ  one-hot owner of transmitter, 0 when none
msg_done  out  NUM_REQ  1-cycle pulse: last byte of message transmitted
tx_enable  out  1  to UART transmitter and bps counter start; high while a byte is in flight
tx_data  out  8  byte to transmit, stable while tx_enable high
tx_done  in  1  1-cycle pulse from transmitter: stop bit finished
busy  out  1  high in every state except IDLE
timeout_err  out  1  1-cycle pulse on tx_done timeout

Behaviour:
- Reset (rst sampled high at clk edge): state IDLE; all outputs 0; rr_ptr=0; gap and timeout counters 0. Reset mid-byte drops tx_enable at once; no ack/done pulses issued.
- States: IDLE, LOAD, SEND, ACK, GAP.
- IDLE:
  - Scan req starting at rr_ptr, wrapping mod NUM_REQ; first set bit wins.
  - req seen in cycle T -> grant one-hot in T+1, state LOAD.
- LOAD (1 cycle):
  - If req[g]=0 -> abort: grant cleared, no msg_done, go GAP.
  - Else register tx_data<=byte_data[g], last_q<=byte_last[g], clear timeout counter, go SEND.
- SEND:
  - tx_enable=1, tx_data held constant.
  - tx_done=1 -> byte_ack[g]=1 next cycle, tx_enable=0, go ACK.
  - Timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without tx_done: tx_enable=0, timeout_err pulse, grant cleared, no byte_ack/msg_done, go GAP.
  - tx_done arriving in the same cycle as the terminal count counts as success.
- ACK (1 cycle, byte_ack[g] high):
  - If last_q: msg_done[g] pulses in this same cycle, grant cleared next cycle, rr_ptr<=(g+1) mod NUM_REQ, go GAP.
  - Else go LOAD. Requester updates byte_data/byte_last on the clock edge ending ACK. tx_enable is therefore low for exactly 2 cycles between bytes (ACK, LOAD).
- GAP:
  - Counts GAP_CYCLES cycles with all outputs low except busy, then IDLE.
  - GAP_CYCLES=0 -> go straight to IDLE.
  - rr_ptr also advances past g on abort and timeout.
- tx_done outside SEND is ignored.
- Requests arriving during a grant wait; req changes of non-granted requesters have no effect until IDLE.
- Single-byte message (byte_last high at first LOAD): one SEND, then ACK with byte_ack and msg_done together.
- Invariants: grant is one-hot or zero; byte_ack and msg_done only on the granted bit; at most one byte_ack per tx_done.

Test Plan:
- NUM_REQ=3, GAP_CYCLES=4, req=3'b001, 3-byte message 0x41,0x54,0x0D (last on 0x0D), tx_done 10 cycles after each tx_enable rise -> tx_data sequence 41,54,0D; three byte_ack[0] pulses; msg_done[0] with third ack; tx_enable low 2 cycles between bytes; grant=0 for 4 gap cycles; busy low afterwards.
- req=3'b111 held, 1-byte messages 0xA0/0xA1/0xA2 -> grants in order 001,010,100,001; each requester's request dropped after its msg_done; no requester served twice while others pending.
- Single-byte message with byte_last=1 -> one SEND; byte_ack and msg_done asserted in same cycle.
- Grant to req[1], tx_done never pulses, TIMEOUT_CYCLES=20 -> tx_enable falls after 20 SEND cycles; timeout_err pulse; no byte_ack; next grant goes to req[2] if pending.
- req[0] dropped mid-message during ACK -> LOAD aborts; no further tx_enable; no msg_done; GAP entered.
- rst high for 1 cycle while tx_enable=1 -> next cycle all outputs 0, state IDLE; late tx_done ignored; rr_ptr=0, so req=3'b110 grants 010.
